// File: rtl/fetch_decode_pipe_pkg.sv
// Shared constants and types for the fetch/decode front end of the RV32I core.
// Covers the NOP encoding, reset defaults, register-field positions and the IF/ID payload.
package fetch_decode_pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          CTRL_W_DEFAULT   = 16;

    localparam int REG_IDX_W = 5;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int RD_LSB    = 7;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
    } ifIdT;

    // A decode bubble carries a NOP so downstream field slices read as x0.
    localparam ifIdT IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pcPlus4: 32'h0};

    function automatic logic [REG_IDX_W-1:0] regField(input logic [31:0] instr, input int lsb);
        return instr[lsb +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/fetch_decode_pipe_pipe_reg.sv
// Generic pipeline register with asynchronous reset, synchronous clear and hold.
// Clear has priority over enable, so a flush always beats a stall.
module pipe_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= RST_VAL;
        end else if (clr_i) begin
            data_q <= RST_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_decode_pipe.sv
// PC register plus IF/ID and ID/EX pipeline registers for the RV32I core.
// Obeys the hazard unit's stall/flush controls and inserts bubbles while instruction memory is not ready.
module fetch_decode_pipe
    import fetch_decode_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CTRL_W   = CTRL_W_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 StallF_i,
    input  logic                 StallD_i,
    input  logic                 FlushD_i,
    input  logic                 FlushE_i,
    input  logic                 PCSrcE_i,
    input  logic [31:0]          PCTargetE_i,
    output logic                 IMemReq_o,
    output logic [31:0]          IMemAddr_o,
    input  logic                 IMemReady_i,
    input  logic [31:0]          IMemRData_i,
    output logic [31:0]          InstrD_o,
    output logic [31:0]          PCD_o,
    output logic [31:0]          PCPlus4D_o,
    output logic                 ValidD_o,
    output logic [4:0]           Rs1D_o,
    output logic [4:0]           Rs2D_o,
    output logic [4:0]           RdD_o,
    input  logic [CTRL_W-1:0]    CtrlD_i,
    output logic [CTRL_W-1:0]    CtrlE_o,
    output logic [4:0]           Rs1E_o,
    output logic [4:0]           Rs2E_o,
    output logic [4:0]           RdE_o,
    output logic [31:0]          PCE_o,
    output logic [31:0]          PCPlus4E_o,
    output logic                 ValidE_o
);

    localparam int IDEX_W = 1 + CTRL_W + 3 * REG_IDX_W + 64;

    logic [31:0] pcF_q, pcF_d;
    logic [31:0] pcPlus4F;
    logic        req_q;
    logic        fetchOk;

    ifIdT        ifId_d, ifId_q;
    logic [IDEX_W-1:0] idEx_d, idEx_q;
    logic [CTRL_W-1:0] ctrlGated;

    // Memory data only counts when a request was actually outstanding.
    assign fetchOk  = req_q & IMemReady_i;
    assign pcPlus4F = pcF_q + 32'd4;

    always_comb begin
        pcF_d = pcF_q;
        if (PCSrcE_i) begin
            pcF_d = PCTargetE_i;
        end else if (!StallF_i && fetchOk) begin
            pcF_d = pcPlus4F;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcF_q <= RESET_PC;
            req_q <= 1'b0;
        end else begin
            pcF_q <= pcF_d;
            req_q <= 1'b1;
        end
    end

    assign IMemReq_o  = req_q;
    assign IMemAddr_o = pcF_q;

    assign ifId_d = '{valid: 1'b1, instr: IMemRData_i, pc: pcF_q, pcPlus4: pcPlus4F};

    pipe_reg #(
        .W       ($bits(ifIdT)),
        .RST_VAL (IFID_BUBBLE)
    ) uIfId (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (!StallD_i),
        .clr_i (FlushD_i | (!StallD_i & !fetchOk)),
        .d_i   (ifId_d),
        .q_o   (ifId_q)
    );

    assign InstrD_o   = ifId_q.instr;
    assign PCD_o      = ifId_q.pc;
    assign PCPlus4D_o = ifId_q.pcPlus4;
    assign ValidD_o   = ifId_q.valid;
    assign Rs1D_o     = regField(ifId_q.instr, RS1_LSB);
    assign Rs2D_o     = regField(ifId_q.instr, RS2_LSB);
    assign RdD_o      = regField(ifId_q.instr, RD_LSB);

    assign ctrlGated = ifId_q.valid ? CtrlD_i : '0;
    assign idEx_d    = {ifId_q.valid, ctrlGated, Rs1D_o, Rs2D_o, RdD_o, ifId_q.pc, ifId_q.pcPlus4};

    // ID/EX never holds; a load-use stall is realised by flushing it.
    pipe_reg #(
        .W (IDEX_W)
    ) uIdEx (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .clr_i (FlushE_i),
        .d_i   (idEx_d),
        .q_o   (idEx_q)
    );

    assign {ValidE_o, CtrlE_o, Rs1E_o, Rs2E_o, RdE_o, PCE_o, PCPlus4E_o} = idEx_q;

endmodule
